irq_pend_ctrl: RTL and testbench
================================

IRQ_PEND_CTRL -- requirements
Module: irq_pend_ctrl

Interface
REQ-001 SHALL have parameter EDGE_MODE, default 1; 1 = rising-edge capture of req, 0 = level capture.
REQ-002 SHALL have port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 16, interrupt request lines, synchronous to clk; bit 15 is highest priority.
REQ-005 SHALL have port mask, input, 16, per-line enable; 1 = eligible.
REQ-006 SHALL have port en, input, 1, global presentation enable.
REQ-007 SHALL have port irq_ready, input, 1, consumer accept.
REQ-008 SHALL have port clr_ovr, input, 1, single-cycle pulse that clears all overrun bits.
REQ-009 SHALL have port irq_valid, output, 1, an interrupt id is presented.
REQ-010 SHALL have port irq_id, output, 4, presented line number (0..15).
REQ-011 SHALL have port pend, output, 16, registered pending vector.
REQ-012 SHALL have port overrun, output, 16, sticky per-line overrun flags.

Function
REQ-013 SHALL register req into req_d every cycle. In EDGE_MODE=1, rise[i] SHALL be req[i]&~req_d[i]. In EDGE_MODE=0, rise[i] SHALL be req[i].
REQ-014 SHALL set pend[i] at the edge where rise[i]=1.
REQ-015 SHALL clear pend[irq_id] at the edge where irq_valid&irq_ready=1. If rise on the same bit occurs in the same cycle, set wins: pend stays 1 and overrun is not set.
REQ-016 In EDGE_MODE=1, SHALL set overrun[i] when rise[i]=1 and pend[i]=1 already and bit i is not being cleared this cycle. In EDGE_MODE=0, overrun SHALL stay 0.
REQ-017 clr_ovr SHALL zero overrun at the next edge. A new overrun condition in the same cycle SHALL win for its bit.
REQ-018 eligible SHALL be pend&mask. The selected id SHALL be the highest-numbered set bit of eligible.
REQ-019 FSM SHALL have 2 states, IDLE and PRESENT:
- IDLE→PRESENT when en=1 and |eligible; irq_valid and irq_id are registered on that edge.
- PRESENT→IDLE on irq_valid&irq_ready.
REQ-020 irq_valid SHALL be 1 exactly in PRESENT. irq_id SHALL be held stable throughout PRESENT; there is no preemption, even if a higher line or a mask change arrives.
REQ-021 Latency: with req first sampled high at edge k (EDGE_MODE=1, idle, enabled, mask=1):
- pend[i]=1 after edge k;
- irq_valid=1, irq_id=i after edge k+1.
REQ-022 After each accept, at least one IDLE cycle SHALL occur (irq_valid=0) before the next presentation.
REQ-023 en=0 SHALL block IDLE→PRESENT only. An interrupt already presented SHALL complete normally.
REQ-024 irq_ready while in IDLE SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: req_d=0, pend=0, overrun=0, state=IDLE, irq_valid=0, irq_id=0.
REQ-026 A req line high at reset release SHALL be detected as a rise on the first active edge.
REQ-027 Reset asserted mid-PRESENT SHALL drop irq_valid immediately and discard all pending state.

Structure
REQ-028 Package irq_pkg SHALL hold NIRQ=16, ID_W=4, and the state encoding IDLE=0, PRESENT=1.
REQ-029 Priority selection SHALL instantiate the existing encoder_164 (A=eligible, EI=1). irq_id source SHALL be its L, and GS SHALL serve as "any eligible". No other sub-module.

Verification
REQ-030 Single edge: req=0x0020 from idle, mask=0xFFFF, en=1, ready=1 → irq_valid at k+1 with irq_id=5; pend=0 after accept.
REQ-031 Priority: req 0x0101 in one cycle → ids 8 then 0, separated by ≥1 idle cycle.
REQ-032 No preemption: id 3 presented, ready=0, then rise on 14 → irq_id stays 3 until accept; 14 presented next.
REQ-033 Overrun: second rise on line 7 while pend[7]=1, unaccepted → overrun=0x0080. clr_ovr → 0x0000. Rise coincident with accept of 7 → pend[7]=1, overrun stays 0.
REQ-034 Mask/en: mask=0xFFFE, req bit 0 → pend[0]=1 but no irq_valid. Set mask bit 0 → presented. en=0 during PRESENT → accept still completes.
REQ-035 Reset: rst_n low mid-PRESENT → irq_valid=0, pend=0 with no clk edge. req held high across release → captured on the first edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared sizes and FSM encoding for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned NIRQ = 16;
  localparam int unsigned ID_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/encoder_164.sv
// 16-to-4 priority encoder: L is the index of the highest set bit of A, GS flags any bit set.
module encoder_164
  import irq_pkg::*;
(
  input  logic [NIRQ-1:0] A,
  input  logic            EI,
  output logic [ID_W-1:0] L,
  output logic            GS
);

  always_comb begin
    L = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (A[i]) L = ID_W'(i);
    end
    if (!EI) L = '0;
    GS = EI & (|A);
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Captures request lines into a pending vector and presents the highest eligible line
// through a valid/ready handshake, tracking per-line overruns in edge mode.
module irq_pend_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] req,
  input  logic [NIRQ-1:0] mask,
  input  logic            en,
  input  logic            irq_ready,
  input  logic            clr_ovr,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  output logic [NIRQ-1:0] pend,
  output logic [NIRQ-1:0] overrun
);

  state_e          state_q;
  logic [ID_W-1:0] irq_id_q;
  logic [NIRQ-1:0] req_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] overrun_q, overrun_d;
  logic [NIRQ-1:0] rise, clr_vec, ovr_set, eligible;
  logic [ID_W-1:0] enc_id;
  logic            any_elig;
  logic            accept;

  assign eligible = pend_q & mask;

  encoder_164 u_enc (
    .A  (eligible),
    .EI (1'b1),
    .L  (enc_id),
    .GS (any_elig)
  );

  always_comb begin
    rise      = (EDGE_MODE != 0) ? (req & ~req_d) : req;
    accept    = (state_q == PRESENT) & irq_ready;
    clr_vec   = accept ? (NIRQ'(1) << irq_id_q) : '0;
    // A new capture on the line being accepted keeps it pending and is not an overrun.
    pend_d    = (pend_q & ~clr_vec) | rise;
    ovr_set   = (EDGE_MODE != 0) ? (rise & pend_q & ~clr_vec) : '0;
    overrun_d = (clr_ovr ? '0 : overrun_q) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d     <= '0;
      pend_q    <= '0;
      overrun_q <= '0;
    end else begin
      req_d     <= req;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  // Returning to IDLE on accept guarantees one idle cycle before the next presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && any_elig) begin
            state_q  <= PRESENT;
            irq_id_q <= enc_id;
          end
        end
        PRESENT: begin
          if (irq_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_id    = irq_id_q;
  assign pend      = pend_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Bench for irq_pend_ctrl: edge- and level-mode instances against a per-line reference model,
// plus directed vectors with hand-derived expectations.
module tb_irq_pend_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, mask;
  logic        en, irq_ready, clr_ovr;

  logic        valid_e, valid_l;
  logic [3:0]  id_e, id_l;
  logic [15:0] pend_e, pend_l, ovr_e, ovr_l;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_pend_ctrl #(.EDGE_MODE(1)) u_dut_edge (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .en(en), .irq_ready(irq_ready),
    .clr_ovr(clr_ovr), .irq_valid(valid_e), .irq_id(id_e), .pend(pend_e), .overrun(ovr_e)
  );

  irq_pend_ctrl #(.EDGE_MODE(0)) u_dut_level (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .en(en), .irq_ready(irq_ready),
    .clr_ovr(clr_ovr), .irq_valid(valid_l), .irq_id(id_l), .pend(pend_l), .overrun(ovr_l)
  );

  // Reference model, index 0 = level mode, 1 = edge mode.
  bit m_pend[2][16];
  bit m_ovr[2][16];
  bit m_pres[2];
  int m_id[2];
  bit m_prev[16];

  typedef struct {
    logic [15:0] req;
    logic [15:0] mask;
    logic        en;
    logic        rdy;
    logic        clr;
    logic        valid;
    logic [3:0]  id;
    logic [15:0] pend;
    logic [15:0] ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] r, logic [15:0] m, logic e, logic rd, logic c,
                              logic v, logic [3:0] id, logic [15:0] p, logic [15:0] o);
    vec_t t;
    t.req = r; t.mask = m; t.en = e; t.rdy = rd; t.clr = c;
    t.valid = v; t.id = id; t.pend = p; t.ovr = o;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        m_pend[m][i] = 1'b0;
        m_ovr[m][i]  = 1'b0;
      end
      m_pres[m] = 1'b0;
      m_id[m]   = 0;
    end
    for (int i = 0; i < 16; i++) m_prev[i] = 1'b0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit np[16];
    bit no[16];
    bit r, clr, acc, found;
    for (int m = 0; m < 2; m++) begin
      acc = m_pres[m] && irq_ready;
      for (int i = 0; i < 16; i++) begin
        r     = (m == 1) ? (req[i] && !m_prev[i]) : req[i];
        clr   = acc && (m_id[m] == i);
        np[i] = r || (m_pend[m][i] && !clr);
        no[i] = ((m == 1) && r && m_pend[m][i] && !clr) || (m_ovr[m][i] && !clr_ovr);
      end
      if (m_pres[m]) begin
        if (acc) m_pres[m] = 1'b0;
      end else if (en) begin
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
          if (!found && m_pend[m][i] && mask[i]) begin
            found     = 1'b1;
            m_pres[m] = 1'b1;
            m_id[m]   = i;
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        m_pend[m][i] = np[i];
        m_ovr[m][i]  = no[i];
      end
    end
    for (int i = 0; i < 16; i++) m_prev[i] = req[i];
  endtask

  task automatic compare_model();
    logic [15:0] ep, eo;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        ep[i] = m_pend[m][i];
        eo[i] = m_ovr[m][i];
      end
      if (m == 1) begin
        check("model_valid_edge", {31'd0, valid_e}, {31'd0, m_pres[1]});
        check("model_pend_edge", {16'd0, pend_e}, {16'd0, ep});
        check("model_ovr_edge", {16'd0, ovr_e}, {16'd0, eo});
        if (m_pres[1]) check("model_id_edge", {28'd0, id_e}, m_id[1]);
      end else begin
        check("model_valid_level", {31'd0, valid_l}, {31'd0, m_pres[0]});
        check("model_pend_level", {16'd0, pend_l}, {16'd0, ep});
        check("model_ovr_level", {16'd0, ovr_l}, {16'd0, eo});
        if (m_pres[0]) check("model_id_level", {28'd0, id_l}, m_id[0]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; mask = 16'hFFFF; en = 1'b1; irq_ready = 1'b1; clr_ovr = 1'b0;
    model_reset();
    #12;
    compare_model();
    check("reset_valid", {31'd0, valid_e}, 32'd0);
    rst_n = 1'b1;

    // req, mask, en, rdy, clr -> valid, id, pend, ovr (after the edge)
    vecs.push_back(mk(16'h0020, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0020, 16'h0000));
    vecs.push_back(mk(16'h0020, 16'hFFFF, 1, 1, 0, 1, 5, 16'h0020, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0101, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0101, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 1, 8, 16'h0101, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 1, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0080, 16'hFFFF, 1, 0, 0, 0, 0, 16'h0080, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 0, 0, 1, 7, 16'h0080, 16'h0000));
    vecs.push_back(mk(16'h0080, 16'hFFFF, 1, 0, 0, 1, 7, 16'h0080, 16'h0080));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 0, 1, 1, 7, 16'h0080, 16'h0000));
    vecs.push_back(mk(16'h0080, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0080, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 1, 7, 16'h0080, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0001, 16'hFFFE, 1, 1, 0, 0, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFE, 1, 1, 0, 0, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFE, 1, 1, 0, 0, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 1, 0, 16'h0001, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0002, 16'hFFFF, 0, 1, 0, 0, 0, 16'h0002, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 16'h0002, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 1, 1, 16'h0002, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 1, 0, 0, 0, 16'h0000, 16'h0000));

    foreach (vecs[k]) begin
      req = vecs[k].req; mask = vecs[k].mask; en = vecs[k].en;
      irq_ready = vecs[k].rdy; clr_ovr = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_valid", k), {31'd0, valid_e}, {31'd0, vecs[k].valid});
      check($sformatf("vec%0d_pend", k), {16'd0, pend_e}, {16'd0, vecs[k].pend});
      check($sformatf("vec%0d_ovr", k), {16'd0, ovr_e}, {16'd0, vecs[k].ovr});
      if (vecs[k].valid) check($sformatf("vec%0d_id", k), {28'd0, id_e}, {28'd0, vecs[k].id});
    end
    clr_ovr = 1'b0; en = 1'b1; mask = 16'hFFFF;

    // No preemption: line 3 stays presented while line 14 arrives.
    irq_ready = 1'b0; req = 16'h0008; tick();
    req = 16'h0000; tick();
    check("nopre_first", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd3});
    req = 16'h4000; tick();
    check("nopre_hold_id", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd3});
    check("nopre_pend", {16'd0, pend_e}, 32'h4008);
    req = 16'h0000; tick(); tick();
    check("nopre_still3", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd3});
    irq_ready = 1'b1; tick();
    check("nopre_accept", {15'd0, valid_e, pend_e}, {15'd0, 1'b0, 16'h4000});
    tick();
    check("nopre_next14", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd14});
    tick();
    check("nopre_done", {15'd0, valid_e, pend_e}, 32'd0);

    // Asynchronous reset while presenting, then req held across release.
    irq_ready = 1'b0; req = 16'h0010; tick();
    req = 16'h0000; tick();
    check("rst_pre_present", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd4});
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_valid", {31'd0, valid_e}, 32'd0);
    check("rst_async_pend", {16'd0, pend_e}, 32'd0);
    compare_model();
    req = 16'h0200;
    #2;
    rst_n = 1'b1;
    tick();
    check("rst_release_capture", {16'd0, pend_e}, 32'h0200);
    tick();
    check("rst_release_present", {27'd0, valid_e, id_e}, {27'd0, 1'b1, 4'd9});
    irq_ready = 1'b1; req = 16'h0000; tick(); tick(); tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req       = 16'($urandom & $urandom & $urandom);
      mask      = 16'($urandom | $urandom);
      en        = ($urandom_range(9) != 0);
      irq_ready = ($urandom_range(2) != 0);
      clr_ovr   = ($urandom_range(19) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
